// File: rtl/led_frontpanel_driver.sv
// Front-panel LED stage: PWM dimming, per-bit blink masking and pulse stretching of the PIO LED word.
// Latency 2 cycles from pattern/blink_mask to ledr/ledg; no backpressure (free-running outputs).
module led_frontpanel_driver #(
    parameter int PWM_BITS        = 8,
    parameter int BLINK_PERIODS   = 4096,
    parameter int STRETCH_PERIODS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [26:0]         pattern,
    input  logic [26:0]         blink_mask,
    input  logic [PWM_BITS-1:0] duty,
    output logic [17:0]         ledr,
    output logic [8:0]          ledg,
    output logic                period_tick
);

    localparam logic [15:0]         BLINK_LAST = 16'(BLINK_PERIODS - 1);
    localparam logic [3:0]          STRETCH    = 4'(STRETCH_PERIODS);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};

    logic [26:0]         pat_q, pat_prev_q, mask_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_d;
    logic [15:0]         blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [26:0][3:0]    hold_q, hold_d;
    logic [26:0]         out_q, out_d;
    logic                period_tick_q;

    logic                tick;
    logic                pwm_on;
    logic [26:0]         rise;
    logic [26:0]         lit;

    assign tick   = (pwm_cnt_q == PWM_MAX);
    assign pwm_on = (duty_q == PWM_MAX) || (pwm_cnt_q < duty_q);
    assign rise   = pat_q & ~pat_prev_q;

    // Duty only changes at period boundaries so a period is never partially dimmed.
    always_comb begin
        duty_d        = duty_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            duty_d = duty;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 16'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // A fresh rising edge reloads the stretch counter even on a tick cycle.
    always_comb begin
        hold_d = hold_q;
        lit    = '0;
        for (int i = 0; i < 27; i++) begin
            if (rise[i]) begin
                hold_d[i] = STRETCH;
            end else if (tick && (hold_q[i] != 4'd0)) begin
                hold_d[i] = hold_q[i] - 4'd1;
            end
            lit[i] = pat_q[i] | (hold_q[i] != 4'd0);
        end
        out_d = lit & {27{pwm_on}} & (~mask_q | {27{blink_phase_q}});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pat_q         <= '0;
            pat_prev_q    <= '0;
            mask_q        <= '0;
            pwm_cnt_q     <= '0;
            duty_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            hold_q        <= '0;
            out_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            pat_q         <= pattern;
            pat_prev_q    <= pat_q;
            mask_q        <= blink_mask;
            pwm_cnt_q     <= pwm_cnt_q + 1'b1;
            duty_q        <= duty_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hold_q        <= hold_d;
            out_q         <= out_d;
            period_tick_q <= tick;
        end
    end

    assign ledr        = out_q[17:0];
    assign ledg        = out_q[26:18];
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_led_frontpanel_driver.sv
// Bench for led_frontpanel_driver: directed scenarios plus random traffic against a timeline-based reference model.
module tb_led_frontpanel_driver;

    localparam int PW = 4;
    localparam int P  = 16;
    localparam int B  = 2;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [26:0]   pattern = '0;
    logic [26:0]   blink_mask = '0;
    logic [PW-1:0] duty = '0;
    logic [17:0]   ledr;
    logic [8:0]    ledg;
    logic          period_tick;

    int checks = 0;
    int errors = 0;

    // Model state: e = edges since reset release; everything else is derived from it arithmetically.
    int          e = 0;
    logic [26:0] m_pq = '0, m_pprev = '0, m_mq = '0;
    int          m_dq = 0;
    int          last_load [27];

    led_frontpanel_driver #(.PWM_BITS(PW), .BLINK_PERIODS(B), .STRETCH_PERIODS(S)) dut (
        .clk(clk), .reset_n(reset_n), .pattern(pattern), .blink_mask(blink_mask),
        .duty(duty), .ledr(ledr), .ledg(ledg), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    function automatic int hold_left(input int i);
        int h;
        if (last_load[i] < 0) return 0;
        h = S - (e / P - last_load[i] / P);
        return (h < 0) ? 0 : h;
    endfunction

    function automatic logic [26:0] model_out();
        logic [26:0] o;
        logic        on, phase;
        on    = (m_dq == P - 1) || ((e % P) < m_dq);
        phase = (((e / P) / B) % 2) == 0;
        for (int i = 0; i < 27; i++)
            o[i] = (m_pq[i] || hold_left(i) != 0) && on && (!m_mq[i] || phase);
        return o;
    endfunction

    function automatic void model_reset();
        e = 0; m_pq = '0; m_pprev = '0; m_mq = '0; m_dq = 0;
        for (int i = 0; i < 27; i++) last_load[i] = -1;
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s e=%0d observed=%h expected=%h", tag, e, obs, exp_v);
        end
    endtask

    task automatic step(input logic rst, input logic [26:0] p, input logic [26:0] m, input logic [PW-1:0] d);
        logic [27:0] exp_v;
        logic [26:0] rise;
        @(negedge clk);
        reset_n = rst; pattern = p; blink_mask = m; duty = d;
        if (!rst) begin
            exp_v = '0;
            model_reset();
        end else begin
            exp_v = {(e % P) == P - 1, model_out()};
            rise  = m_pq & ~m_pprev;
            e++;
            m_pprev = m_pq; m_pq = p; m_mq = m;
            if (e % P == 0) m_dq = int'(d);
            for (int i = 0; i < 27; i++) if (rise[i]) last_load[i] = e;
        end
        @(posedge clk); #1;
        check("out", {period_tick, ledg, ledr}, exp_v);
    endtask

    initial begin
        int cnt, cnt2, guard;
        logic [26:0] rp, rm;
        logic [PW-1:0] rd;
        model_reset();

        repeat (3) step(1'b0, '0, '0, '0);
        check("reset_state", {period_tick, ledg, ledr}, 28'h0);

        // Reset release with everything requested on: dark until duty loads.
        repeat (40) step(1'b1, 27'h7FFFFFF, '0, 4'hF);
        check("all_on", {ledg, ledr}, 27'h7FFFFFF);

        cnt = 0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 27'h1, '0, 4'h4);
            if (k >= 32 && ledr[0]) cnt++;
        end
        check("duty4_count", 28'(cnt), 28'd8);

        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 27'h1, '0, 4'h0);
            if (k >= 24 && ledr[0]) cnt++;
        end
        check("duty0_count", 28'(cnt), 28'd0);

        cnt = 0; cnt2 = 0;
        for (int k = 0; k < 128; k++) begin
            step(1'b1, 27'h4000001, 27'h4000000, 4'hF);
            if (k >= 64 && ledg[8]) cnt++;
            if (k >= 64 && ledr[0]) cnt2++;
        end
        check("blink_half", 28'(cnt), 28'd32);
        check("unmasked_steady", 28'(cnt2), 28'd64);

        // Single-cycle pulse at an arbitrary phase, then one whose stretch load lands on a tick.
        repeat (40) step(1'b1, '0, '0, 4'hF);
        step(1'b1, 27'h20, '0, 4'hF);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, '0, '0, 4'hF);
            if (ledr[5]) cnt++;
        end
        check("stretch_min", 28'(cnt >= 17), 28'd1);
        check("stretch_max", 28'(cnt <= 33), 28'd1);

        guard = 0;
        while (e % P != 14 && guard < 64) begin
            step(1'b1, '0, '0, 4'hF);
            guard++;
        end
        step(1'b1, 27'h20, '0, 4'hF);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, '0, '0, 4'hF);
            if (ledr[5]) cnt++;
        end
        check("stretch_on_tick", 28'(cnt), 28'd33);

        // Duty switched mid-period; the model tracks when the new value takes hold.
        guard = 0;
        while (e % P != 2 && guard < 64) begin
            step(1'b1, 27'h1, '0, 4'h8);
            guard++;
        end
        repeat (48) step(1'b1, 27'h1, '0, 4'h2);

        // Reset in the dark blink phase with a stretch pending.
        guard = 0;
        while (!((((e / P) / B) % 2) == 1 && (e % P) == 4) && guard < 200) begin
            step(1'b1, 27'h4000000, 27'h4000000, 4'hF);
            guard++;
        end
        step(1'b1, 27'h4000020, 27'h4000000, 4'hF);
        step(1'b1, 27'h4000000, 27'h4000000, 4'hF);
        step(1'b1, 27'h4000000, 27'h4000000, 4'hF);
        check("pre_reset_hold", 28'(hold_left(5) != 0), 28'd1);
        check("pre_reset_dark", 28'(ledg[8]), 28'd0);
        step(1'b0, 27'h4000000, 27'h4000000, 4'hF);
        check("mid_reset_zero", {period_tick, ledg, ledr}, 28'h0);
        step(1'b1, '0, 27'h4000000, 4'hF);
        check("post_reset_zero", {period_tick, ledg, ledr}, 28'h0);

        rp = '0; rm = '0; rd = 4'hF;
        for (int k = 0; k < 500; k++) begin
            rp = rp ^ (27'($urandom) & 27'($urandom) & 27'($urandom));
            if ($urandom_range(0, 49) == 0) rm = 27'($urandom);
            if ($urandom_range(0, 19) == 0) rd = PW'($urandom);
            step(($urandom_range(0, 199) != 0), rp, rm, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
